// File: rtl/mem_port_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module      : mem_port_arbiter_pkg
// Description : Shared encodings and widths for the memory port arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_port_arbiter_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_PEND = 1'b1;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_INST = 2'd1;
    localparam logic [1:0] OWN_DATA = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mem_port_rsp_router.sv
//------------------------------------------------------------------------------
// Module      : mem_port_rsp_router
// Description : Steers read returns to the fetch or data side and holds them.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_rsp_router
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        issue_owner,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_rvalid,
    output logic [DATA_W-1:0] data_rdata
);

    logic [1:0]        r_owner;
    logic [DATA_W-1:0] r_inst_hold;
    logic [DATA_W-1:0] r_data_hold;
    logic              w_inst_ret;
    logic              w_data_ret;

    // Returns are bypassed so the requester sees the data in the return cycle.
    assign w_inst_ret  = !rst && (r_owner == OWN_INST);
    assign w_data_ret  = !rst && (r_owner == OWN_DATA);
    assign inst_rvalid = w_inst_ret;
    assign inst_rdata  = w_inst_ret ? mem_rdata : r_inst_hold;
    assign data_rdata  = w_data_ret ? mem_rdata : r_data_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner     <= OWN_NONE;
            r_inst_hold <= '0;
            r_data_hold <= '0;
        end else begin
            r_owner <= issue_owner;
            if (w_inst_ret) r_inst_hold <= mem_rdata;
            if (w_data_ret) r_data_hold <= mem_rdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module      : mem_port_arbiter
// Description : Shares one memory port between fetch and data; data wins and a
//               conflicting fetch is replayed. Optional MEM_PORT_ARBITER_PERF_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_en,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_rvalid,
    input  logic                data_en,
    input  logic [DATA_W/8-1:0] data_wen,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stallreq_arb
`ifdef MEM_PORT_ARBITER_PERF_EN
    ,
    output logic [31:0]         conflict_cnt,
    output logic [31:0]         pend_cycles
`endif
);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_pend_addr;
    logic              w_capture;
    logic [1:0]        w_issue_owner;

    always_comb begin
        w_state_nxt   = r_state;
        w_capture     = 1'b0;
        w_issue_owner = OWN_NONE;
        stallreq_arb  = 1'b0;
        mem_en        = 1'b0;
        mem_wen       = '0;
        mem_addr      = '0;
        mem_wdata     = '0;
        if (!rst) begin
            if (data_en) begin
                mem_en        = 1'b1;
                mem_wen       = data_wen;
                mem_addr      = data_addr;
                mem_wdata     = data_wdata;
                w_issue_owner = (data_wen == '0) ? OWN_DATA : OWN_NONE;
            end
            if (r_state == ARB_IDLE) begin
                if (data_en && inst_en) begin
                    w_capture    = 1'b1;
                    w_state_nxt  = ARB_PEND;
                    stallreq_arb = 1'b1;
                end else if (inst_en) begin
                    mem_en        = 1'b1;
                    mem_addr      = inst_addr;
                    w_issue_owner = OWN_INST;
                end
            end else begin
                // IF is frozen here, so inst_en only repeats the captured fetch.
                stallreq_arb = 1'b1;
                if (!data_en) begin
                    mem_en        = 1'b1;
                    mem_addr      = r_pend_addr;
                    w_issue_owner = OWN_INST;
                    w_state_nxt   = ARB_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ARB_IDLE;
            r_pend_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) r_pend_addr <= inst_addr;
        end
    end

    mem_port_rsp_router #(
        .DATA_W (DATA_W)
    ) u_rsp_router (
        .clk         (clk),
        .rst         (rst),
        .issue_owner (w_issue_owner),
        .mem_rdata   (mem_rdata),
        .inst_rdata  (inst_rdata),
        .inst_rvalid (inst_rvalid),
        .data_rdata  (data_rdata)
    );

`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [31:0] r_conflict_cnt;
    logic [31:0] r_pend_cycles;

    assign conflict_cnt = r_conflict_cnt;
    assign pend_cycles  = r_pend_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict_cnt <= '0;
            r_pend_cycles  <= '0;
        end else begin
            if (w_capture && (r_conflict_cnt != 32'hFFFF_FFFF))
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            if (stallreq_arb && (r_pend_cycles != 32'hFFFF_FFFF))
                r_pend_cycles <= r_pend_cycles + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_mem_port_arbiter
// Description : Cycle-vector bench for mem_port_arbiter with a fetch-return queue.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_rvalid;
    logic        data_en;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stallreq_arb;
`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [31:0] conflict_cnt;
    logic [31:0] pend_cycles;
`endif

    mem_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .inst_en      (inst_en),
        .inst_addr    (inst_addr),
        .inst_rdata   (inst_rdata),
        .inst_rvalid  (inst_rvalid),
        .data_en      (data_en),
        .data_wen     (data_wen),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .mem_en       (mem_en),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .stallreq_arb (stallreq_arb)
`ifdef MEM_PORT_ARBITER_PERF_EN
        ,
        .conflict_cnt (conflict_cnt),
        .pend_cycles  (pend_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ie;
        logic [31:0] ia;
        logic        de;
        logic [3:0]  dw;
        logic [31:0] da;
        logic [31:0] dd;
        logic [31:0] mr;
        logic        e_en;
        logic [3:0]  e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_stall;
        logic        e_rv;
        logic [31:0] e_dr;
        logic        push;
        logic [31:0] pval;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] sb[$];
    logic [31:0] last_inst;
    int          n_vec;
    int          n_err;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ie, input logic [31:0] ia, input logic de,
                         input logic [3:0] dw, input logic [31:0] da,
                         input logic [31:0] dd, input logic [31:0] mr);
        inst_en    = ie;
        inst_addr  = ia;
        data_en    = de;
        data_wen   = dw;
        data_addr  = da;
        data_wdata = dd;
        mem_rdata  = mr;
    endtask

    task automatic add_v(input logic ie, input logic [31:0] ia, input logic de,
                         input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
                         input logic [31:0] mr, input logic e_en, input logic [3:0] e_wen,
                         input logic [31:0] e_addr, input logic [31:0] e_wdata,
                         input logic e_stall, input logic e_rv, input logic [31:0] e_dr,
                         input logic push, input logic [31:0] pval);
        vec_t v;
        v.ie = ie; v.ia = ia; v.de = de; v.dw = dw; v.da = da; v.dd = dd; v.mr = mr;
        v.e_en = e_en; v.e_wen = e_wen; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_stall = e_stall; v.e_rv = e_rv; v.e_dr = e_dr; v.push = push; v.pval = pval;
        vq.push_back(v);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        last_inst = 32'h0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h44, 32'h0, 32'h0);
        @(negedge clk);
        check("rst_mem_en", {31'b0, mem_en}, 32'h0);
        check("rst_stall", {31'b0, stallreq_arb}, 32'h0);
        reset_dut();

        //    ie  ia            de  dw    da     dd            mr            en  wen   addr          wdata         st  rv  dr            push pval
        add_v(0, 32'h0,         0, 4'h0, 32'h0, 32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0,        0,  0,  32'h0,        0, 32'h0);
        add_v(1, 32'hBFC0_0000, 0, 4'h0, 32'h0, 32'h0,        32'h0,        1, 4'h0, 32'hBFC0_0000, 32'h0,       0,  0,  32'h0,        1, 32'h2408_0001);
        add_v(0, 32'h0,         0, 4'h0, 32'h0, 32'h0,        32'h2408_0001, 0, 4'h0, 32'h0,       32'h0,        0,  1,  32'h0,        0, 32'h0);
        add_v(1, 32'h100,       1, 4'h0, 32'h200, 32'h0,      32'h0,        1, 4'h0, 32'h200,      32'h0,        1,  0,  32'h0,        0, 32'h0);
        add_v(1, 32'h100,       0, 4'h0, 32'h0, 32'h0,        32'h0000_AAAA, 1, 4'h0, 32'h100,     32'h0,        1,  0,  32'h0000_AAAA, 1, 32'h0000_BBBB);
        add_v(0, 32'h0,         0, 4'h0, 32'h0, 32'h0,        32'h0000_BBBB, 0, 4'h0, 32'h0,       32'h0,        0,  1,  32'h0000_AAAA, 0, 32'h0);
        add_v(1, 32'h300,       1, 4'hF, 32'h400, 32'h1111_1111, 32'h0,     1, 4'hF, 32'h400,      32'h1111_1111, 1, 0,  32'h0000_AAAA, 0, 32'h0);
        add_v(1, 32'h300,       1, 4'hF, 32'h404, 32'h2222_2222, 32'h0,     1, 4'hF, 32'h404,      32'h2222_2222, 1, 0,  32'h0000_AAAA, 0, 32'h0);
        add_v(1, 32'h300,       1, 4'hF, 32'h408, 32'h3333_3333, 32'h0,     1, 4'hF, 32'h408,      32'h3333_3333, 1, 0,  32'h0000_AAAA, 0, 32'h0);
        add_v(1, 32'h300,       1, 4'hF, 32'h40C, 32'h4444_4444, 32'h0,     1, 4'hF, 32'h40C,      32'h4444_4444, 1, 0,  32'h0000_AAAA, 0, 32'h0);
        add_v(1, 32'h300,       0, 4'h0, 32'h0, 32'h0,        32'h0,        1, 4'h0, 32'h300,      32'h0,        1,  0,  32'h0000_AAAA, 1, 32'h5555_AAAA);
        add_v(0, 32'h0,         0, 4'h0, 32'h0, 32'h0,        32'h5555_AAAA, 0, 4'h0, 32'h0,       32'h0,        0,  1,  32'h0000_AAAA, 0, 32'h0);
        add_v(0, 32'h0,         1, 4'h2, 32'h8, 32'h0000_5500, 32'h0,       1, 4'h2, 32'h8,        32'h0000_5500, 0, 0,  32'h0000_AAAA, 0, 32'h0);
        add_v(0, 32'h0,         0, 4'h0, 32'h0, 32'h0,        32'hDEAD_BEEF, 0, 4'h0, 32'h0,       32'h0,        0,  0,  32'h0000_AAAA, 0, 32'h0);
        add_v(0, 32'h0,         1, 4'h0, 32'hC, 32'h0,        32'h0,        1, 4'h0, 32'hC,        32'h0,        0,  0,  32'h0000_AAAA, 0, 32'h0);
        add_v(0, 32'h0,         0, 4'h0, 32'h0, 32'h0,        32'h1234_5678, 0, 4'h0, 32'h0,       32'h0,        0,  0,  32'h1234_5678, 0, 32'h0);
        add_v(1, 32'h500,       0, 4'h0, 32'h0, 32'h0,        32'h0,        1, 4'h0, 32'h500,      32'h0,        0,  0,  32'h1234_5678, 1, 32'h600D_0001);
        add_v(1, 32'h504,       0, 4'h0, 32'h0, 32'h0,        32'h600D_0001, 1, 4'h0, 32'h504,     32'h0,        0,  1,  32'h1234_5678, 1, 32'h600D_0002);
        add_v(0, 32'h0,         0, 4'h0, 32'h0, 32'h0,        32'h600D_0002, 0, 4'h0, 32'h0,       32'h0,        0,  1,  32'h1234_5678, 0, 32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].ie, vq[i].ia, vq[i].de, vq[i].dw, vq[i].da, vq[i].dd, vq[i].mr);
            if (vq[i].push) sb.push_back(vq[i].pval);
            @(negedge clk);
            check($sformatf("v%0d mem_en", i), {31'b0, mem_en}, {31'b0, vq[i].e_en});
            check($sformatf("v%0d mem_wen", i), {28'b0, mem_wen}, {28'b0, vq[i].e_wen});
            check($sformatf("v%0d mem_addr", i), mem_addr, vq[i].e_addr);
            check($sformatf("v%0d mem_wdata", i), mem_wdata, vq[i].e_wdata);
            check($sformatf("v%0d stall", i), {31'b0, stallreq_arb}, {31'b0, vq[i].e_stall});
            check($sformatf("v%0d rvalid", i), {31'b0, inst_rvalid}, {31'b0, vq[i].e_rv});
            check($sformatf("v%0d data_rdata", i), data_rdata, vq[i].e_dr);
            if (inst_rvalid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL v%0d sb_empty: got rvalid=1 expected no fetch return", i);
                end else begin
                    last_inst = sb.pop_front();
                end
            end
            check($sformatf("v%0d inst_rdata", i), inst_rdata, last_inst);
            @(posedge clk);
            #1;
        end
        check("sb_drain", sb.size(), 32'd0);

        // Reset while a fetch is pending: it must never reach the port.
        drive(1'b1, 32'h700, 1'b1, 4'h0, 32'h800, 32'h0, 32'h0);
        @(negedge clk);
        check("pre_rst_stall", {31'b0, stallreq_arb}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        drive(1'b1, 32'h700, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("rst_pend_stall", {31'b0, stallreq_arb}, 32'h0);
        check("rst_pend_mem_en", {31'b0, mem_en}, 32'h0);
        check("rst_pend_rvalid", {31'b0, inst_rvalid}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hFFFF_0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("post_rst%0d mem_en", k), {31'b0, mem_en}, 32'h0);
            check($sformatf("post_rst%0d stall", k), {31'b0, stallreq_arb}, 32'h0);
            check($sformatf("post_rst%0d rvalid", k), {31'b0, inst_rvalid}, 32'h0);
            check($sformatf("post_rst%0d inst_rdata", k), inst_rdata, 32'h0);
            @(posedge clk);
            #1;
        end

`ifdef MEM_PORT_ARBITER_PERF_EN
        reset_dut();
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 32'h900, 1'b1, 4'h0, 32'hA00, 32'h0, 32'h0);
            @(posedge clk);
            #1 drive(1'b1, 32'h900, 1'b1, 4'hF, 32'hA04, 32'h0, 32'h0);
            @(posedge clk);
            #1 drive(1'b1, 32'h900, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
            @(posedge clk);
            #1 drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("conflict_cnt", conflict_cnt, 32'd2);
        check("pend_cycles", pend_cycles, 32'd6);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
